// File: rtl/serial_byte_collector_pkg.sv
// Shared state encoding, default width and parity helper for the serial byte collector.
package serial_byte_collector_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // XOR of every bit: even parity over a zero-extended word
  function automatic logic even_parity32(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_byte_collector_bit_shift_reg.sv
// Parameterized serial-in/parallel-out shift register with shift enable and synchronous clear.
module bit_shift_reg
  import serial_byte_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shreg_r;

  // Shift direction chosen so the first bit of a frame ends at the documented end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (clr) begin
      shreg_r <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        shreg_r <= {shreg_r[WIDTH-2:0], bit_in};
      end else begin
        shreg_r <= {bit_in, shreg_r[WIDTH-1:1]};
      end
    end
  end

  assign q = shreg_r;

endmodule

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel collector with valid/ready output, overrun pulse and sync abort.
// Optional trailing even-parity bit check enabled by defining SERIAL_PARITY_CHECK_EN.
module serial_byte_collector
  import serial_byte_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef SERIAL_PARITY_CHECK_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_HOLD;
`endif

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             shift_en_s, clr_s;
  logic             valid_r, overrun_r, overrun_nxt_s;
  logic [WIDTH-1:0] word_s;

  bit_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .bit_in   (bit_in),
    .q        (word_s)
  );

  // Next-state, counter and handshake decisions
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    shift_en_s    = 1'b0;
    clr_s         = 1'b0;
    overrun_nxt_s = 1'b0;
    if (sync_clr) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
      clr_s       = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bit_valid) begin
            shift_en_s  = 1'b1;
            cnt_nxt_s   = CNT_ONE;
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_valid) begin
            shift_en_s = 1'b1;
            cnt_nxt_s  = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_nxt_s = ST_AFTER_DATA;
            end else begin
              state_nxt_s = ST_SHIFT;
            end
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        // Parity bit is consumed here and never enters the word
        ST_PARITY: begin
          if (bit_valid) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_PARITY;
          end
        end
        ST_HOLD: begin
          if (byte_ready) begin
            if (bit_valid) begin
              shift_en_s  = 1'b1;
              cnt_nxt_s   = CNT_ONE;
              state_nxt_s = ST_SHIFT;
            end else begin
              cnt_nxt_s   = '0;
              state_nxt_s = ST_IDLE;
            end
          end else if (bit_valid) begin
            overrun_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      valid_r   <= (state_nxt_s == ST_HOLD);
      overrun_r <= overrun_nxt_s;
    end
  end

  assign byte_out   = word_s;
  assign byte_valid = valid_r;
  assign overrun    = overrun_r;

`ifdef SERIAL_PARITY_CHECK_EN
  logic [31:0] word32_s;
  logic        parity_err_r, parity_err_nxt_s;

  // Parity status latched when the parity bit arrives, cleared on accept/abort
  always_comb begin
    word32_s              = 32'd0;
    word32_s[WIDTH-1:0]   = word_s;
    parity_err_nxt_s      = parity_err_r;
    if (sync_clr) begin
      parity_err_nxt_s = 1'b0;
    end else if ((state_r == ST_PARITY) && bit_valid) begin
      parity_err_nxt_s = even_parity32(word32_s) ^ bit_in;
    end else if ((state_r == ST_HOLD) && byte_ready) begin
      parity_err_nxt_s = 1'b0;
    end else begin
      parity_err_nxt_s = parity_err_r;
    end
  end

  // Parity status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= parity_err_nxt_s;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed self-checking bench: one MSB-first and one LSB-first collector fed the same bit stream.
module tb_serial_byte_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_out_m, byte_out_l;
  logic       valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  always #5 clk = ~clk;

  serial_byte_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out_m), .byte_valid(valid_m), .byte_ready(byte_ready),
    .overrun(ovr_m), .parity_err(perr_m)
  );

  serial_byte_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out_l), .byte_valid(valid_l), .byte_ready(byte_ready),
    .overrun(ovr_l), .parity_err(perr_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Sends w[nb-1] down to w[0], then the even-parity bit of w when parity is built in
  task automatic send_word(input logic [7:0] w, input int nb, input bit gaps);
    for (int i = nb - 1; i >= 0; i--) send_bit(w[i], gaps ? (i % 4) : 0);
`ifdef SERIAL_PARITY_CHECK_EN
    send_bit(^w, 0);
`endif
  endtask

  task automatic accept();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_byte_out", {24'd0, byte_out_m}, 32'h0);
    check("rst_valid", {31'd0, valid_m}, 32'h0);
    check("rst_overrun", {31'd0, ovr_m | ovr_l}, 32'h0);
    check("rst_parity", {31'd0, perr_m | perr_l}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    check("partial_shift", {24'd0, byte_out_m}, 32'h1F);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_m", {24'd0, byte_out_m}, 32'h0);
    check("async_rst_out_l", {24'd0, byte_out_l}, 32'h0);
    check("async_rst_valid", {31'd0, valid_m}, 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // 0xA5 with idle gaps
    send_word(8'hA5, 8, 1'b1);
    check("a5_valid", {31'd0, valid_m}, 32'h1);
    check("a5_msb", {24'd0, byte_out_m}, 32'hA5);
    check("a5_lsb", {24'd0, byte_out_l}, 32'hA5);
    accept();
    check("a5_accept", {31'd0, valid_m}, 32'h0);

    // Bits 1,1,0,0,0,0,0,0
    send_word(8'hC0, 8, 1'b0);
    check("c0_msb", {24'd0, byte_out_m}, 32'hC0);
    check("c0_lsb", {24'd0, byte_out_l}, 32'h03);
    accept();

    // Backpressure and overrun
    send_word(8'h3C, 8, 1'b0);
    check("3c_valid", {31'd0, valid_m}, 32'h1);
    send_bit(1'b1, 0);
    check("ovr_pulse_m", {31'd0, ovr_m}, 32'h1);
    check("ovr_pulse_l", {31'd0, ovr_l}, 32'h1);
    check("ovr_hold_out", {24'd0, byte_out_m}, 32'h3C);
    check("ovr_hold_valid", {31'd0, valid_m}, 32'h1);
    tick();
    check("ovr_one_cycle", {31'd0, ovr_m}, 32'h0);
    check("ovr_still_3c", {24'd0, byte_out_m}, 32'h3C);
    accept();
    check("bp_release", {31'd0, valid_m}, 32'h0);

    // Zero-bubble: accept 0xFF while the first bit of 0x00 arrives
    send_word(8'hFF, 8, 1'b0);
    check("ff_msb", {24'd0, byte_out_m}, 32'hFF);
    byte_ready = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b0;
    tick();
    byte_ready = 1'b0;
    bit_valid  = 1'b0;
    check("zb_accept", {31'd0, valid_m}, 32'h0);
    check("zb_no_ovr", {31'd0, ovr_m}, 32'h0);
    send_word(8'h00, 7, 1'b0);
    check("zb_valid", {31'd0, valid_m}, 32'h1);
    check("zb_msb", {24'd0, byte_out_m}, 32'h00);
    check("zb_lsb", {24'd0, byte_out_l}, 32'h00);
    accept();

    // Abort during SHIFT at bit 4, with a bit presented in the abort cycle
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    sync_clr  = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    sync_clr  = 1'b0;
    bit_valid = 1'b0;
    check("clr_valid", {31'd0, valid_m}, 32'h0);
    send_word(8'h81, 8, 1'b0);
    check("81_valid", {31'd0, valid_m}, 32'h1);
    check("81_msb", {24'd0, byte_out_m}, 32'h81);
    check("81_lsb", {24'd0, byte_out_l}, 32'h81);
    check("81_parity", {31'd0, perr_m}, 32'h0);
    accept();

    // Abort of a held word
    send_word(8'h5A, 8, 1'b0);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check("clr_hold_valid", {31'd0, valid_m}, 32'h0);
    tick();
    check("clr_stays_idle", {31'd0, valid_m}, 32'h0);

`ifdef SERIAL_PARITY_CHECK_EN
    begin
      logic [7:0] pw;
      pw = 8'h81;
      for (int i = 7; i >= 0; i--) send_bit(pw[i], 0);
      check("par_wait", {31'd0, valid_m}, 32'h0);
      send_bit(1'b1, 0);
      check("par_bad_valid", {31'd0, valid_m}, 32'h1);
      check("par_bad_err", {31'd0, perr_m}, 32'h1);
      check("par_bad_word", {24'd0, byte_out_m}, 32'h81);
      accept();
      check("par_clear", {31'd0, perr_m}, 32'h0);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
